db_store_ctrl: RTL

DB_STORE_CTRL -- requirements
Module: db_store_ctrl

---
 rtl/db_store_ctrl_pkg.sv | 22 ++
 rtl/db_store_ctrl_if.sv | 36 +++
 rtl/db_store_fifo.sv | 47 ++++
 rtl/db_store_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/db_store_ctrl_pkg.sv
// rtl/db_store_ctrl_pkg.sv - shared state encoding and store-buffer size constants
// Purpose: FSM state type and luma/chroma word counts shared by the DB store controller.
// Also supplies a default PIXEL_WIDTH when the build does not define one.
// Ports: none (package).
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

package db_store_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } store_state_t;

  localparam int NWORDS_LUMA   = 128;
  localparam int NWORDS_CHROMA = 64;

endpackage

// File: rtl/db_store_ctrl_if.sv
// rtl/db_store_ctrl_if.sv - external bus handshake bundle of the DB store controller
// Purpose: groups bus request/grant, word stream and LCU position signals.
// Ports (master = controller side):
//   bus_req_o/bus_ack_i      bus request / grant
//   bus_valid_o/bus_ready_i  word handshake
//   bus_data_o, bus_last_o   word and last-word-of-LCU flag
//   bus_x_o, bus_y_o         position of the LCU being stored
interface db_store_ctrl_if #(
  parameter int DATA_W = 256,
  parameter int LCU_XW = 8
) ();

  logic              bus_req_o;
  logic              bus_ack_i;
  logic              bus_valid_o;
  logic              bus_ready_i;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_last_o;
  logic [LCU_XW-1:0] bus_x_o;
  logic [LCU_XW-1:0] bus_y_o;

  modport master (
    output bus_req_o, input bus_ack_i,
    output bus_valid_o, input bus_ready_i,
    output bus_data_o, output bus_last_o,
    output bus_x_o, output bus_y_o
  );

  modport slave (
    input bus_req_o, output bus_ack_i,
    input bus_valid_o, output bus_ready_i,
    input bus_data_o, input bus_last_o,
    input bus_x_o, input bus_y_o
  );

endinterface

// File: rtl/db_store_fifo.sv
// rtl/db_store_fifo.sv - 2-entry output FIFO between store-RAM reads and the bus
// Purpose: buffers read words so bus backpressure never drops data.
// Ports: clk, rstn (async active-low); wr_en/wr_data push; rd_en pops;
//        rd_data is the head entry; count is the occupancy (0..2).
// The caller guarantees no push when full and no pop when empty.
module db_store_fifo #(
  parameter int W = 257
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/db_store_ctrl.sv
// rtl/db_store_ctrl.sv - drains deblocked LCU buffers from the store RAM onto the external bus
// Purpose: tracks how many of the 3 DB buffers are full, and for each full buffer
// requests the bus, reads NWORDS words from the store RAM through a 2-entry FIFO
// and streams them out tagged with the LCU (x,y) position.
// Build option: DB_STORE_CHROMA_EN -> 192 words per LCU (luma + interleaved uv),
// otherwise 128 luma words.
// Ports:
//   clk, rstn                        clock, async active-low reset
//   sysif_start_i                    picture start, clears LCU position
//   cfg_lcu_w_i, cfg_lcu_h_i         last LCU x / y index of the picture
//   db_done_i, db_stall_o            DB buffer filled / all buffers full
//   store_en_o, store_addr_o,
//   store_data_i, store_done_o       store-RAM read port and buffer-drained pulse
//   bus (db_store_ctrl_if.master)    bus request, word stream, LCU position
//   ovf_err_o                        sticky buffer overflow error
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module db_store_ctrl
  import db_store_ctrl_pkg::*;
#(
  parameter int STORE_AW = 8,
  parameter int DATA_W   = 32*`PIXEL_WIDTH,
  parameter int LCU_XW   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sysif_start_i,
  input  logic [LCU_XW-1:0]   cfg_lcu_w_i,
  input  logic [LCU_XW-1:0]   cfg_lcu_h_i,
  input  logic                db_done_i,
  output logic                db_stall_o,
  output logic                store_en_o,
  output logic [STORE_AW-1:0] store_addr_o,
  input  logic [DATA_W-1:0]   store_data_i,
  output logic                store_done_o,
  db_store_ctrl_if.master     bus,
  output logic                ovf_err_o
);

`ifdef DB_STORE_CHROMA_EN
  localparam int NWORDS = NWORDS_LUMA + NWORDS_CHROMA;
`else
  localparam int NWORDS = NWORDS_LUMA;
`endif
  localparam logic [STORE_AW-1:0] LAST_ADDR = STORE_AW'(NWORDS - 1);

  store_state_t        state, state_nx;
  logic [1:0]          occ;
  logic                db_accept;
  logic [STORE_AW-1:0] rd_addr;
  logic                rd_last;
  logic                inflight;
  logic                inflight_last;
  logic [1:0]          fifo_cnt;
  logic [DATA_W:0]     fifo_head;
  logic                pop;
  logic [2:0]          slots_used;
  logic [LCU_XW-1:0]   pos_x, pos_y;
  logic                start_pend;
  logic                bus_req;
  logic                store_done;

  // A full set of buffers only accepts a new one if one drains in the same cycle.
  assign db_accept  = db_done_i && ((occ != 2'd3) || store_done);
  assign db_stall_o = (occ == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ       <= 2'd0;
      ovf_err_o <= 1'b0;
    end else begin
      case ({db_accept, store_done})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (db_done_i && !db_accept) begin
        ovf_err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bus_req    = 1'b0;
    store_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (occ != 2'd0) state_nx = ST_REQ;
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus.bus_ack_i) state_nx = ST_READ;
      end
      ST_READ: begin
        bus_req = 1'b1;
        if (store_en_o && rd_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        bus_req = 1'b1;
        if ((fifo_cnt == 2'd0) && !inflight) state_nx = ST_DONE;
      end
      ST_DONE: begin
        store_done = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign store_done_o  = store_done;
  assign bus.bus_req_o = bus_req;

  // Read issue: count the slot freed by this cycle's pop, so a steady
  // ready stream gets one word per cycle while a stalled bus never sees
  // more than 2 words outstanding (FIFO entries + read in flight).
  assign pop        = bus.bus_valid_o && bus.bus_ready_i;
  assign slots_used = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_last    = (rd_addr == LAST_ADDR);
  assign store_en_o   = (state == ST_READ) && (slots_used < 3'd2);
  assign store_addr_o = rd_addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= store_en_o;
      inflight_last <= store_en_o && rd_last;
      if (store_en_o) begin
        rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
      end
    end
  end

  // The last-word flag travels with the data through the FIFO.
  db_store_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (inflight),
    .wr_data ({inflight_last, store_data_i}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_cnt)
  );

  assign bus.bus_valid_o = (fifo_cnt != 2'd0);
  assign bus.bus_data_o  = bus.bus_valid_o ? fifo_head[DATA_W-1:0] : '0;
  assign bus.bus_last_o  = bus.bus_valid_o && fifo_head[DATA_W];

  // Position only moves in IDLE (start clear) or DONE (advance), so it is
  // stable for the whole REQ..DONE window of a store.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_x      <= '0;
      pos_y      <= '0;
      start_pend <= 1'b0;
    end else if ((state == ST_IDLE) && (sysif_start_i || start_pend)) begin
      pos_x      <= '0;
      pos_y      <= '0;
      start_pend <= 1'b0;
    end else begin
      if (sysif_start_i) start_pend <= 1'b1;
      if (store_done) begin
        if (pos_x == cfg_lcu_w_i) begin
          pos_x <= '0;
          pos_y <= (pos_y == cfg_lcu_h_i) ? '0 : pos_y + 1'b1;
        end else begin
          pos_x <= pos_x + 1'b1;
        end
      end
    end
  end

  assign bus.bus_x_o = pos_x;
  assign bus.bus_y_o = pos_y;

endmodule
